fft_stage_scheduler: RTL
========================

Name: fft_stage_scheduler

Overview:
- Sequences the radix-2 FFT datapath stage by stage: per-butterfly read addresses, twiddle addresses, write addresses and write enable.
- Inserts a pipeline drain between stages so that no stage reads a location before the previous stage has written it.
- Drives the 2-bank memory select.
- Sits between the start/done interface of the FFT top level and the memory_2_bank, twiddle ROM and butterfly pipeline.

Parameters:
- LOG2N, 5, log2 of FFT size (N = 2^LOG2N points, N/2 butterflies per stage, LOG2N stages).
- PIPE_LAT, 9, cycles from read address presented to the corresponding write; ROM, memory and butterfly latency are combined in this value. Must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous active-high reset.
- start_fft  in  1  request to start one transform; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- fft_done  out  1  one-cycle pulse when the last write of the last stage has completed.
- stage  out  3  current stage index, 0..LOG2N-1.
- bank_select  out  1  memory bank select, forwarded to memory_2_bank.
- mema_address  out  LOG2N  butterfly upper-leg read address.
- memb_address  out  LOG2N  butterfly lower-leg read address.
- twiddle_address  out  LOG2N-1  twiddle ROM address.
- rd_valid  out  1  high when the read and twiddle addresses are valid this cycle.
- mem_write  out  1  write enable, already aligned to the write cycle.
- wr_mema_address  out  LOG2N  upper-leg write address, aligned with mem_write.
- wr_memb_address  out  LOG2N  lower-leg write address, aligned with mem_write.

Behaviour:
- Reset: clr=1 forces the following immediately, regardless of the clock:
  - state IDLE; all outputs 0;
  - stage, k and drain counters 0;
  - write pipeline valid bits cleared.
  - A clr mid-transform aborts with no further mem_write pulses and no fft_done.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_fft=1 → ISSUE, with stage=0, k=0, bank_select=0.
  - start_fft is ignored in every other state.
- ISSUE:
  - One butterfly per cycle, rd_valid=1, k from 0 to N/2-1.
  - Leaving ISSUE after k=N/2-1 → DRAIN, with drain count 0.
- Address rule (decimation in frequency):
  - span = 2^(LOG2N-1-stage)
  - group = k >> (LOG2N-1-stage)
  - pos = k & (span-1)
  - mema = group*2*span + pos
  - memb = mema + span
  - twiddle = pos << stage, truncated to LOG2N-1 bits.
- Write alignment:
  - {valid, mema, memb} enter a PIPE_LAT-deep shift register.
  - mem_write and the write addresses appear exactly PIPE_LAT cycles after the matching rd_valid cycle.
- DRAIN:
  - Lasts PIPE_LAT cycles; during them rd_valid=0 and the read addresses hold their last values.
  - At the end, if stage < LOG2N-1: stage+1, bank_select toggles, k=0 → ISSUE.
  - Otherwise → DONE.
- Ordering guarantee: the first read of stage s+1 happens strictly after the last write of stage s.
- DONE:
  - fft_done=1 and busy=1 for exactly one cycle, then → IDLE with busy=0.
  - stage and bank_select hold their values until the next start.
  - A start_fft asserted during the DONE cycle is dropped.
- Timing:
  - Start to fft_done: 1 + LOG2N*(N/2+PIPE_LAT) cycles, i.e. 126 for the defaults.
  - LOG2N-1 bank toggles per transform.
- Counter widths:
  - k is LOG2N-1 bits; its wrap from N/2-1 ends the stage.
  - The drain counter is clog2(PIPE_LAT+1) bits.
  - No arithmetic overflow is possible within the ranges above.

Decomposition:
- Shared package fft_pkg:
  - LOG2N and PIPE_LAT defaults;
  - N and N/2 as derived constants;
  - the state enumeration {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module, fft_bfly_addr: combinational (stage, k) → (mema, memb, twiddle). It is also used by the bench as its reference model.
- The write pipeline is a local shift register, not a separate module.

Test Plan:
- Reset then single start_fft pulse →
  - cycle 1: stage 0, k=0, mema=0, memb=16, twiddle=0, rd_valid=1;
  - k=15: mema=15, memb=31, twiddle=15;
  - mem_write first high 9 cycles after the first rd_valid.
- Stage coverage:
  - stage 1, k=9 → mema=17, memb=25, twiddle=2;
  - stage 4, k=3 → mema=6, memb=7, twiddle=0;
  - all 80 butterflies match fft_bfly_addr, and every address 0..31 is read exactly once per stage.
- Drain and bank →
  - exactly 9 rd_valid=0 cycles between stages;
  - bank_select toggles 4 times;
  - fft_done single pulse 126 cycles after start;
  - 80 mem_write pulses total.
- start_fft held high for the whole transform plus the DONE cycle →
  - no restart while busy;
  - the DONE-cycle start is dropped;
  - start_fft still high in the IDLE cycle that follows DONE starts the next transform.
- clr asserted mid stage 2 during ISSUE →
  - outputs 0 asynchronously;
  - no mem_write pulses afterwards;
  - no fft_done;
  - a subsequent start runs a full 126-cycle transform from stage 0.
- PIPE_LAT=1, LOG2N=3 →
  - 3 stages of 4 butterflies;
  - done after 1 + 3*(4+1) = 16 cycles;
  - no read of stage s+1 in the same cycle as a write of stage s.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the radix-2 FFT stage scheduler.
package fft_pkg;
  localparam int DEF_LOG2N    = 5;
  localparam int DEF_PIPE_LAT = 9;
  localparam int DEF_N        = 1 << DEF_LOG2N;
  localparam int DEF_HALF_N   = DEF_N / 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/fft_bfly_addr.sv
// Decimation-in-frequency butterfly address unit: (stage, k) -> upper/lower leg and twiddle address.
module fft_bfly_addr import fft_pkg::*; #(
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic [2:0]       i_stage,
  input  logic [LOG2N-2:0] i_k,
  output logic [LOG2N-1:0] o_mema,
  output logic [LOG2N-1:0] o_memb,
  output logic [LOG2N-2:0] o_twiddle
);
  localparam logic [LOG2N-2:0] K_ONE     = 1;
  localparam logic [LOG2N-1:0] A_ONE     = 1;
  localparam logic [2:0]       TOP_SHIFT = 3'(LOG2N - 1);

  logic [2:0]       w_shift;
  logic [LOG2N-2:0] w_posMask;
  logic [LOG2N-2:0] w_pos;
  logic [LOG2N-2:0] w_groupBits;
  logic [LOG2N-1:0] w_span;

  assign w_shift     = TOP_SHIFT - i_stage;
  // In stage 0 the shifted one falls off the top, so the subtraction still gives span-1 = N/2-1.
  assign w_posMask   = (K_ONE << w_shift) - K_ONE;
  assign w_pos       = i_k & w_posMask;
  assign w_groupBits = i_k & ~w_posMask;
  assign w_span      = A_ONE << w_shift;

  // group*span with the pos bits cleared, doubled by one more shift, then pos re-inserted.
  assign o_mema    = {w_groupBits, 1'b0} | {1'b0, w_pos};
  assign o_memb    = o_mema | w_span;
  assign o_twiddle = w_pos << i_stage;
endmodule

// File: rtl/fft_stage_scheduler.sv
// Stage-by-stage radix-2 FFT sequencer: issues one butterfly per cycle, drains the pipeline between stages.
module fft_stage_scheduler import fft_pkg::*; #(
  parameter int LOG2N    = DEF_LOG2N,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_fft,
  output logic             busy,
  output logic             fft_done,
  output logic [2:0]       stage,
  output logic             bank_select,
  output logic [LOG2N-1:0] mema_address,
  output logic [LOG2N-1:0] memb_address,
  output logic [LOG2N-2:0] twiddle_address,
  output logic             rd_valid,
  output logic             mem_write,
  output logic [LOG2N-1:0] wr_mema_address,
  output logic [LOG2N-1:0] wr_memb_address
);
  localparam int               DW         = $clog2(PIPE_LAT + 1);
  localparam logic [2:0]       LAST_STAGE = 3'(LOG2N - 1);
  localparam logic [2:0]       STAGE_ONE  = 3'd1;
  localparam logic [LOG2N-2:0] K_ONE      = 1;
  localparam logic [LOG2N-2:0] K_LAST     = '1;
  localparam logic [DW-1:0]    DRAIN_ONE  = 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef struct packed {
    logic             valid;
    logic [LOG2N-1:0] mema;
    logic [LOG2N-1:0] memb;
  } wr_slot_t;

  state_t           r_state;
  logic [2:0]       r_stage;
  logic [LOG2N-2:0] r_k;
  logic [DW-1:0]    r_drain;
  logic             r_busy;
  logic             r_done;
  logic             r_bank;
  logic             r_rdValid;
  logic [LOG2N-1:0] r_mema;
  logic [LOG2N-1:0] r_memb;
  logic [LOG2N-2:0] r_twiddle;
  wr_slot_t         r_wrPipe [PIPE_LAT];

  logic [2:0]       w_nextStage;
  logic [LOG2N-2:0] w_nextK;
  logic [LOG2N-1:0] w_mema;
  logic [LOG2N-1:0] w_memb;
  logic [LOG2N-2:0] w_twiddle;

  // Addresses are computed for the butterfly about to be issued so they can be registered.
  always_comb begin
    w_nextStage = r_stage;
    w_nextK     = r_k + K_ONE;
    if (r_state == IDLE) begin
      w_nextStage = '0;
      w_nextK     = '0;
    end else if (r_state == DRAIN) begin
      w_nextStage = r_stage + STAGE_ONE;
      w_nextK     = '0;
    end
  end

  fft_bfly_addr #(.LOG2N(LOG2N)) u_bflyAddr (
    .i_stage   (w_nextStage),
    .i_k       (w_nextK),
    .o_mema    (w_mema),
    .o_memb    (w_memb),
    .o_twiddle (w_twiddle)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_stage   <= '0;
      r_k       <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bank    <= 1'b0;
      r_rdValid <= 1'b0;
      r_mema    <= '0;
      r_memb    <= '0;
      r_twiddle <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_fft) begin
            r_state   <= ISSUE;
            r_stage   <= w_nextStage;
            r_k       <= w_nextK;
            r_bank    <= 1'b0;
            r_busy    <= 1'b1;
            r_rdValid <= 1'b1;
            r_mema    <= w_mema;
            r_memb    <= w_memb;
            r_twiddle <= w_twiddle;
          end
        end
        ISSUE: begin
          r_k <= w_nextK;
          if (r_k == K_LAST) begin
            r_state   <= DRAIN;
            r_drain   <= '0;
            r_rdValid <= 1'b0;
          end else begin
            r_mema    <= w_mema;
            r_memb    <= w_memb;
            r_twiddle <= w_twiddle;
          end
        end
        DRAIN: begin
          if (r_drain != DRAIN_LAST) begin
            r_drain <= r_drain + DRAIN_ONE;
          end else if (r_stage == LAST_STAGE) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ISSUE;
            r_stage   <= w_nextStage;
            r_k       <= w_nextK;
            r_bank    <= ~r_bank;
            r_rdValid <= 1'b1;
            r_mema    <= w_mema;
            r_memb    <= w_memb;
            r_twiddle <= w_twiddle;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read-side valid and addresses travel PIPE_LAT cycles to line up with the butterfly result.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < PIPE_LAT; i++) r_wrPipe[i] <= '0;
    end else begin
      r_wrPipe[0] <= {r_rdValid, r_mema, r_memb};
      for (int i = 1; i < PIPE_LAT; i++) r_wrPipe[i] <= r_wrPipe[i-1];
    end
  end

  assign busy            = r_busy;
  assign fft_done        = r_done;
  assign stage           = r_stage;
  assign bank_select     = r_bank;
  assign mema_address    = r_mema;
  assign memb_address    = r_memb;
  assign twiddle_address = r_twiddle;
  assign rd_valid        = r_rdValid;
  assign mem_write       = r_wrPipe[PIPE_LAT-1].valid;
  assign wr_mema_address = r_wrPipe[PIPE_LAT-1].mema;
  assign wr_memb_address = r_wrPipe[PIPE_LAT-1].memb;
endmodule
